product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Downstream consumer of the 4x4 array multiplier's 8-bit product.
- Accepts a stream of products over a valid/ready handshake and sums a programmable block of 1–16 of them into a saturating accumulator.
- Returns each block sum as two 8-bit beats (low byte, then high byte) over a second valid/ready handshake.
- Fits the existing dedicated-I/O pin budget: product in on one byte, result out on one byte.

Parameters:
- ACC_W, 12, accumulator width in bits; legal range 9..16; default holds the worst case 16 × 225 = 3600.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort; discards the partial block and any pending result.
- len  input  4  block length; 1..15 literal, 0 means 16; sampled on the first accepted product of a block.
- prod_in  input  8  multiplier product.
- prod_valid  input  1  prod_in is valid.
- prod_ready  output  1  block can accept a product this cycle.
- res_data  output  8  result beat.
- res_valid  output  1  res_data is valid.
- res_ready  input  1  consumer accepts the beat.
- res_last  output  1  high on the second (high-byte) beat.
- ovf  output  1  saturation occurred in this block; valid while res_valid=1, otherwise 0.
- busy  output  1  high when a block is partially accumulated or a result is pending.

Behaviour:
- Reset (async, rst=1): state=ACCUM, acc=0, cnt=0, len_q=0, sat=0. Outputs: prod_ready=1, res_valid=0, res_data=0, res_last=0, ovf=0, busy=0.
- FSM states: ACCUM, SEND_LO, SEND_HI.
- ACCUM:
  - prod_ready=1, res_valid=0.
  - A product is accepted when prod_valid & prod_ready.
  - On accept: acc <= min(acc + prod_in, 2^ACC_W − 1). sat <= sat | (saturation occurred). cnt <= cnt + 1.
  - If cnt==0 at accept, len_q <= len (0 maps to 16). len changes mid-block are ignored.
  - When the accepted product is the len_q-th (first product when len=1), go to SEND_LO next cycle.
- SEND_LO:
  - prod_ready=0, res_valid=1, res_data=acc[7:0], res_last=0, ovf=sat.
  - On res_ready, go to SEND_HI.
- SEND_HI:
  - prod_ready=0, res_valid=1, res_data = acc[ACC_W−1:8] zero-extended to 8 bits, res_last=1, ovf=sat.
  - On res_ready, go to ACCUM with acc=0, cnt=0, sat=0.
- Outputs are registered/state-decoded only; no combinational path from prod_valid or res_ready to any output.
- While res_valid=1 and res_ready=0: res_data, res_last and ovf stay stable; prod_valid is ignored.
- Latency and throughput:
  - The first result beat is valid the cycle after the last product is accepted.
  - With res_ready held high, a block of L products occupies L+2 cycles; prod_ready is low for exactly 2 cycles.
- Saturation: clamp at 2^ACC_W − 1 and never wrap. Once saturated, further adds hold the ceiling.
- clear=1 (sync): forces ACCUM with acc=0, cnt=0, sat=0 at the next edge, from any state.
  - clear takes priority over a simultaneous product accept or result handshake; that product or beat is dropped.
  - prod_ready stays per current state during the clear cycle.
- busy = (state != ACCUM) | (cnt != 0).
- rst asserted mid-operation returns immediately to reset values; the partial block and any pending result are lost.

Test Plan:
- len=4, products 0x09, 0x10, 0xE1, 0x01 back-to-back, res_ready=1 → beats 0xFB (res_last=0), then 0x00 (res_last=1); ovf=0; prod_ready low for exactly 2 cycles; first beat one cycle after the 4th accept.
- len=0, 16 × 0xE1 → beats 0x10, then 0x0E (3600); ovf=0; len changed to 3 after the 2nd product has no effect.
- len=2, products 0x05, 0x06, res_ready=0 for 5 cycles → res_valid=1 with res_data=0x0B held stable; prod_ready=0; prod_valid pulses ignored. Then res_ready=1 → 0x0B, 0x00; next block accepted normally.
- ACC_W=10, len=5, 5 × 0xE1 → beats 0xFF, 0x03 (0x3FF saturated), ovf=1; following block len=1, product 0x02 → 0x02, 0x00 with ovf=0.
- len=4, accept 0x30 and 0x40, pulse clear coincident with a third prod_valid → acc discarded, busy=0. Then len=1, product 0x07 → 0x07, 0x00.
- rst pulsed asynchronously (between edges) while in SEND_HI → res_valid=0 and prod_ready=1 immediately; after release, a len=1 product 0x21 → 0x21, 0x00.

Source files
------------

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - saturating block accumulator for 8-bit products, result out as two byte beats
module product_accumulator #(
    parameter int ACC_W = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [3:0] len,
    input  logic [7:0] prod_in,
    input  logic       prod_valid,
    output logic       prod_ready,
    output logic [7:0] res_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_last,
    output logic       ovf,
    output logic       busy
);

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [4:0]       cnt;
    logic [4:0]       len_q;
    logic             sat;

    logic             accept;
    logic             last_prod;
    logic [4:0]       len_eff;
    logic [4:0]       cnt_inc;
    logic [ACC_W:0]   sum;
    logic [15:0]      acc_ext;

    assign accept    = (state == ACCUM) && prod_valid;
    // len is only honoured on the first product of a block; afterwards the latched copy rules
    assign len_eff   = (cnt == 5'd0) ? ((len == 4'd0) ? 5'd16 : {1'b0, len}) : len_q;
    assign cnt_inc   = cnt + 5'd1;
    assign last_prod = (cnt_inc == len_eff);
    assign sum       = {1'b0, acc} + (ACC_W + 1)'(prod_in);
    assign acc_ext   = 16'(acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (accept && last_prod) state_nxt = SEND_LO;
                SEND_LO: if (res_ready) state_nxt = SEND_HI;
                SEND_HI: if (res_ready) state_nxt = ACCUM;
                default: state_nxt = ACCUM;
            endcase
        end
    end

    always_comb begin
        prod_ready = (state == ACCUM);
        res_valid  = (state != ACCUM);
        res_last   = (state == SEND_HI);
        ovf        = (state != ACCUM) && sat;
        busy       = (state != ACCUM) || (cnt != 5'd0);
        res_data   = 8'h00;
        case (state)
            SEND_LO: res_data = acc_ext[7:0];
            SEND_HI: res_data = acc_ext[15:8];
            default: res_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            sat   <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (accept) begin
            // a carry out of the accumulator means the true sum exceeded the ceiling
            acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
            sat <= sat | sum[ACC_W];
            cnt <= cnt_inc;
            if (cnt == 5'd0) len_q <= len_eff;
        end else if ((state == SEND_HI) && res_ready) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - directed bench for product_accumulator
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [3:0] len;
    logic [7:0] prod_in;
    logic       prod_valid;
    logic       res_ready;

    logic       a_prod_ready, a_res_valid, a_res_last, a_ovf, a_busy;
    logic [7:0] a_res_data;
    logic       b_prod_ready, b_res_valid, b_res_last, b_ovf, b_busy;
    logic [7:0] b_res_data;

    logic       sel;
    logic       o_prod_ready, o_res_valid, o_res_last, o_ovf, o_busy;
    logic [7:0] o_res_data;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] pv [16];

    always #5 clk = ~clk;

    product_accumulator dut (
        .clk(clk), .rst(rst), .clear(clear), .len(len), .prod_in(prod_in),
        .prod_valid(prod_valid), .prod_ready(a_prod_ready), .res_data(a_res_data),
        .res_valid(a_res_valid), .res_ready(res_ready), .res_last(a_res_last),
        .ovf(a_ovf), .busy(a_busy)
    );

    product_accumulator #(.ACC_W(10)) dut10 (
        .clk(clk), .rst(rst), .clear(clear), .len(len), .prod_in(prod_in),
        .prod_valid(prod_valid), .prod_ready(b_prod_ready), .res_data(b_res_data),
        .res_valid(b_res_valid), .res_ready(res_ready), .res_last(b_res_last),
        .ovf(b_ovf), .busy(b_busy)
    );

    assign o_prod_ready = sel ? b_prod_ready : a_prod_ready;
    assign o_res_valid  = sel ? b_res_valid  : a_res_valid;
    assign o_res_last   = sel ? b_res_last   : a_res_last;
    assign o_ovf        = sel ? b_ovf        : a_ovf;
    assign o_busy       = sel ? b_busy       : a_busy;
    assign o_res_data   = sel ? b_res_data   : a_res_data;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input string tag, input int n, input logic [3:0] l, input logic [3:0] l_after);
        for (int i = 0; i < n; i++) begin
            len        = (i >= 2) ? l_after : l;
            prod_in    = pv[i];
            prod_valid = 1'b1;
            check({tag, "_prdy_acc"}, int'(o_prod_ready), 1);
            step();
        end
        prod_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [7:0] lo, input logic [7:0] hi, input logic ov);
        res_ready = 1'b1;
        check({tag, "_lo_valid"}, int'(o_res_valid), 1);
        check({tag, "_lo_data"}, int'(o_res_data), int'(lo));
        check({tag, "_lo_last"}, int'(o_res_last), 0);
        check({tag, "_lo_ovf"}, int'(o_ovf), int'(ov));
        check({tag, "_lo_prdy"}, int'(o_prod_ready), 0);
        step();
        check({tag, "_hi_data"}, int'(o_res_data), int'(hi));
        check({tag, "_hi_last"}, int'(o_res_last), 1);
        check({tag, "_hi_ovf"}, int'(o_ovf), int'(ov));
        check({tag, "_hi_prdy"}, int'(o_prod_ready), 0);
        step();
        check({tag, "_done_prdy"}, int'(o_prod_ready), 1);
        check({tag, "_done_valid"}, int'(o_res_valid), 0);
        check({tag, "_done_busy"}, int'(o_busy), 0);
        check({tag, "_done_ovf"}, int'(o_ovf), 0);
    endtask

    initial begin
        sel        = 1'b0;
        rst        = 1'b1;
        clear      = 1'b0;
        len        = 4'd0;
        prod_in    = 8'h00;
        prod_valid = 1'b0;
        res_ready  = 1'b1;
        #12;
        check("rst_prdy", int'(o_prod_ready), 1);
        check("rst_valid", int'(o_res_valid), 0);
        check("rst_data", int'(o_res_data), 0);
        check("rst_last", int'(o_res_last), 0);
        check("rst_ovf", int'(o_ovf), 0);
        check("rst_busy", int'(o_busy), 0);
        rst = 1'b0;
        step();

        // 9 + 16 + 225 + 1 = 251
        pv[0] = 8'h09; pv[1] = 8'h10; pv[2] = 8'hE1; pv[3] = 8'h01;
        feed("t1", 4, 4'd4, 4'd4);
        expect_result("t1", 8'hFB, 8'h00, 1'b0);

        // 16 x 225 = 3600 = 0xE10; len switched to 3 mid-block
        for (int i = 0; i < 16; i++) pv[i] = 8'hE1;
        feed("t2", 16, 4'd0, 4'd3);
        expect_result("t2", 8'h10, 8'h0E, 1'b0);

        // consumer stalls five cycles while producer keeps offering
        pv[0] = 8'h05; pv[1] = 8'h06;
        res_ready = 1'b0;
        feed("t3", 2, 4'd2, 4'd2);
        for (int i = 0; i < 5; i++) begin
            prod_valid = i[0];
            prod_in    = 8'h77;
            check("t3_stall_valid", int'(o_res_valid), 1);
            check("t3_stall_data", int'(o_res_data), 8'h0B);
            check("t3_stall_last", int'(o_res_last), 0);
            check("t3_stall_prdy", int'(o_prod_ready), 0);
            step();
        end
        prod_valid = 1'b0;
        expect_result("t3", 8'h0B, 8'h00, 1'b0);
        pv[0] = 8'h03;
        feed("t3b", 1, 4'd1, 4'd1);
        expect_result("t3b", 8'h03, 8'h00, 1'b0);

        // 10-bit accumulator: 5 x 225 = 1125 clamps to 0x3FF
        sel = 1'b1;
        for (int i = 0; i < 5; i++) pv[i] = 8'hE1;
        feed("t4", 5, 4'd5, 4'd5);
        expect_result("t4", 8'hFF, 8'h03, 1'b1);
        pv[0] = 8'h02;
        feed("t4b", 1, 4'd1, 4'd1);
        expect_result("t4b", 8'h02, 8'h00, 1'b0);
        sel = 1'b0;

        // clear wins over a coincident product
        pv[0] = 8'h30; pv[1] = 8'h40;
        feed("t5", 2, 4'd4, 4'd4);
        check("t5_busy_mid", int'(o_busy), 1);
        prod_in    = 8'h50;
        prod_valid = 1'b1;
        clear      = 1'b1;
        check("t5_prdy_clr", int'(o_prod_ready), 1);
        step();
        clear      = 1'b0;
        prod_valid = 1'b0;
        check("t5_busy", int'(o_busy), 0);
        check("t5_valid", int'(o_res_valid), 0);
        pv[0] = 8'h07;
        feed("t5b", 1, 4'd1, 4'd1);
        expect_result("t5b", 8'h07, 8'h00, 1'b0);

        // async reset while the high beat is pending
        pv[0] = 8'h11;
        feed("t6", 1, 4'd1, 4'd1);
        step();
        res_ready = 1'b0;
        check("t6_in_hi", int'(o_res_last), 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", int'(o_res_valid), 0);
        check("t6_rst_prdy", int'(o_prod_ready), 1);
        check("t6_rst_busy", int'(o_busy), 0);
        rst       = 1'b0;
        res_ready = 1'b1;
        step();
        pv[0] = 8'h21;
        feed("t6b", 1, 4'd1, 4'd1);
        expect_result("t6b", 8'h21, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
